// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: control sequencer for 4-bit shift-add multiply and
// restoring divide. It drives the ALU op strobes and the ACC high/low
// shift/load selects one cycle at a time. The result is left in ACC high:low.
module muldiv_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       mode,
  input  logic [3:0] breg_data,
  input  logic       alu_cout,
  input  logic       carry_flag,
  input  logic       acc_low_lsb,
  output logic       op_mul,
  output logic       op_div,
  output logic       alu_lsb,
  output logic       acc_in_select,
  output logic [1:0] acc_high_select,
  output logic [1:0] acc_low_select,
  output logic       fill_value,
  output logic       acc_high_clear,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MUL_ADD,
    S_MUL_SHIFT,
    S_DIV_SHIFT,
    S_DIV_SUB,
    S_DIV_FIX,
    S_DONE
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_SHR   = 2'b01;
  localparam logic [1:0] SEL_SHL   = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  state_t     r_state;
  state_t     w_next;
  logic       r_mode;
  logic [1:0] r_cnt;
  logic       r_qbit;
  logic       r_dbz;
  logic       w_dbz_req;

  // A divide request with a zero divisor is answered at once, without
  // touching the ACC.
  assign w_dbz_req = mode && (breg_data == 4'd0);

  // The op strobes depend on the state only. They are kept out of the Mealy
  // select logic because the ALU carry-out that feeds that logic depends on them.
  assign op_mul        = (r_state == S_MUL_ADD);
  assign op_div        = (r_state == S_DIV_SUB);
  assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done          = (r_state == S_DONE);
  assign div_by_zero   = r_dbz;
  assign acc_in_select = 1'b0;

  // State register plus iteration counter, quotient bit, latched mode and
  // divide-by-zero flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_cnt   <= 2'd0;
      r_qbit  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_dbz_req) begin
              r_dbz <= 1'b1;
            end else begin
              r_mode <= mode;
              r_dbz  <= 1'b0;
              r_cnt  <= 2'd0;
              r_qbit <= 1'b0;
            end
          end
        end
        S_MUL_SHIFT: begin
          if (r_cnt != 2'd3) r_cnt <= r_cnt + 2'd1;
        end
        S_DIV_SUB: begin
          r_qbit <= alu_cout;
          if (r_cnt != 2'd3) r_cnt <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and datapath controls. The selects in MUL_ADD and DIV_SUB
  // follow the current multiplier bit and ALU carry-out.
  always_comb begin
    w_next          = r_state;
    alu_lsb         = 1'b0;
    acc_high_select = SEL_HOLD;
    acc_low_select  = SEL_HOLD;
    fill_value      = 1'b0;
    acc_high_clear  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = w_dbz_req ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        acc_high_clear = 1'b1;
        w_next         = r_mode ? S_DIV_SHIFT : S_MUL_ADD;
      end
      S_MUL_ADD: begin
        alu_lsb         = acc_low_lsb;
        acc_high_select = acc_low_lsb ? SEL_LOAD : SEL_HOLD;
        w_next          = S_MUL_SHIFT;
      end
      S_MUL_SHIFT: begin
        acc_high_select = SEL_SHR;
        acc_low_select  = SEL_SHR;
        fill_value      = carry_flag;
        w_next          = (r_cnt == 2'd3) ? S_DONE : S_MUL_ADD;
      end
      S_DIV_SHIFT: begin
        acc_high_select = SEL_SHL;
        acc_low_select  = SEL_SHL;
        fill_value      = r_qbit;
        w_next          = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        // Without a borrow the difference is kept. Otherwise ACC high simply
        // holds, which restores the partial remainder.
        acc_high_select = alu_cout ? SEL_LOAD : SEL_HOLD;
        w_next          = (r_cnt == 2'd3) ? S_DIV_FIX : S_DIV_SHIFT;
      end
      S_DIV_FIX: begin
        // The last quotient bit still has to be shifted into ACC low.
        acc_low_select = SEL_SHL;
        fill_value     = r_qbit;
        w_next         = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer. It contains a behavioural ACC/ALU model, so
// the sequencer drives a real datapath, and it checks final ACC contents and
// timing against a scoreboard.
module tb_muldiv_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, start, mode;
  logic [3:0] breg;
  logic       alu_cout, carry_flag, acc_low_lsb;
  logic       op_mul, op_div, alu_lsb, acc_in_select;
  logic [1:0] acc_high_select, acc_low_select;
  logic       fill_value, acc_high_clear, busy, done, div_by_zero;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .mode            (mode),
    .breg_data       (breg),
    .alu_cout        (alu_cout),
    .carry_flag      (carry_flag),
    .acc_low_lsb     (acc_low_lsb),
    .op_mul          (op_mul),
    .op_div          (op_div),
    .alu_lsb         (alu_lsb),
    .acc_in_select   (acc_in_select),
    .acc_high_select (acc_high_select),
    .acc_low_select  (acc_low_select),
    .fill_value      (fill_value),
    .acc_high_clear  (acc_high_clear),
    .busy            (busy),
    .done            (done),
    .div_by_zero     (div_by_zero)
  );

  // ---------------- ACC / ALU model ----------------
  logic [3:0] acc_h, acc_l;
  logic       cf;
  logic       ld_en;
  logic [7:0] ld_val;
  logic [4:0] sum;
  logic [3:0] alu_out;
  logic [3:0] nh, nl;

  assign sum         = {1'b0, acc_h} + {1'b0, breg};
  assign alu_out     = op_div ? (acc_h - breg) : sum[3:0];
  assign alu_cout    = op_div ? (acc_h >= breg) : sum[4];
  assign carry_flag  = cf;
  assign acc_low_lsb = acc_l[0];

  always_comb begin
    nh = acc_h;
    nl = acc_l;
    case (acc_high_select)
      2'b01: nh = {fill_value, acc_h[3:1]};
      2'b10: nh = {acc_h[2:0], acc_l[3]};
      2'b11: nh = alu_out;
      default: nh = acc_h;
    endcase
    case (acc_low_select)
      2'b01: nl = {acc_h[0], acc_l[3:1]};
      2'b10: nl = {acc_l[2:0], fill_value};
      2'b11: nl = alu_out;
      default: nl = acc_l;
    endcase
    if (acc_high_clear) nh = 4'd0;
  end

  always @(posedge clk) begin
    if (ld_en) begin
      {acc_h, acc_l} <= ld_val;
      cf <= 1'b0;
    end else begin
      acc_h <= nh;
      acc_l <= nl;
      if (op_mul) cf <= alu_lsb & sum[4];
    end
  end

  // ---------------- checking ----------------
  logic [12:0] outs;
  assign outs = {op_mul, op_div, alu_lsb, acc_in_select, acc_high_select,
                 acc_low_select, fill_value, acc_high_clear, busy, done, div_by_zero};

  typedef struct {
    int       cyc;
    logic [7:0] acc;
    logic     dbz;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  logic fill_seen, hs_in_add, any_act;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Preload ACC low with a, issue start, then follow the operation to done.
  // poke > 0 injects a one-cycle start pulse (with the other mode) in that cycle.
  task automatic run_op(input string tag, input logic m, input logic [3:0] a,
                        input logic [3:0] b, input int poke);
    exp_t e;
    exp_t got;
    int   cyc;
    logic busy1, dbz1;
    @(negedge clk);
    ld_en = 1'b1; ld_val = {4'h0, a}; breg = b;
    @(negedge clk);
    ld_en = 1'b0; mode = m; start = 1'b1;
    e.dbz = m && (b == 4'd0);
    if (e.dbz) begin
      e.cyc = 1; e.acc = {4'h0, a};
    end else if (m) begin
      e.cyc = 11; e.acc = {4'(a % b), 4'(a / b)};
    end else begin
      e.cyc = 10; e.acc = 8'(a * b);
    end
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    fill_seen = 1'b0; hs_in_add = 1'b0; any_act = 1'b0;
    busy1 = busy; dbz1 = div_by_zero;
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == poke) begin
        start = 1'b1; mode = ~m;
      end else if (c == poke + 1) begin
        start = 1'b0; mode = m;
      end
      if (acc_high_select == 2'b01 && fill_value) fill_seen = 1'b1;
      if (op_mul && acc_high_select != 2'b00) hs_in_add = 1'b1;
      if (op_mul | op_div | acc_high_clear | busy | (|acc_high_select) | (|acc_low_select))
        any_act = 1'b1;
      if (done) begin
        cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    got = sb.pop_front();
    check({tag, "_done_cycle"}, 16'(cyc), 16'(got.cyc));
    check({tag, "_acc"}, {8'h0, acc_h, acc_l}, {8'h0, got.acc});
    check({tag, "_dbz"}, 16'(div_by_zero), 16'(got.dbz));
    check({tag, "_busy_c1"}, 16'(busy1), 16'(!got.dbz));
    check({tag, "_dbz_c1"}, 16'(dbz1), 16'(got.dbz));
    @(posedge clk); #1;
    check({tag, "_post_idle"},
          16'({done, busy, acc_high_select, acc_low_select, op_mul, op_div, acc_high_clear}),
          16'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; breg = 4'd0;
    ld_en = 1'b1; ld_val = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 16'(outs), 16'd0);
    @(negedge clk);
    reset_n = 1'b1; ld_en = 1'b0;

    run_op("mul_13x11", 1'b0, 4'd13, 4'd11, 0);
    run_op("mul_15x15", 1'b0, 4'd15, 4'd15, 0);
    check("mul_15x15_carry_fill", 16'(fill_seen), 16'd1);
    run_op("mul_0x9", 1'b0, 4'd0, 4'd9, 0);
    check("mul_0x9_no_add_load", 16'(hs_in_add), 16'd0);
    run_op("mul_9x0", 1'b0, 4'd9, 4'd0, 0);
    run_op("div_13_3", 1'b1, 4'd13, 4'd3, 0);
    run_op("div_15_1", 1'b1, 4'd15, 4'd1, 0);
    run_op("div_7_0", 1'b1, 4'd7, 4'd0, 0);
    check("div_7_0_no_activity", 16'(any_act), 16'd0);
    check("dbz_holds", 16'(div_by_zero), 16'd1);
    run_op("div_13_3_after_dbz", 1'b1, 4'd13, 4'd3, 0);
    run_op("mul_start_ignored", 1'b0, 4'd13, 4'd11, 3);

    // Abort a multiply in the MUL_SHIFT of iteration 2 with reset.
    @(negedge clk);
    ld_en = 1'b1; ld_val = 8'h0D; breg = 4'd11;
    @(negedge clk);
    ld_en = 1'b0; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_in_mul_shift", 16'({busy, acc_high_select, acc_low_select}), 16'b1_01_01);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort_outputs_idle", 16'(outs), 16'd0);
    reset_n = 1'b1;
    run_op("mul_13x11_after_reset", 1'b0, 4'd13, 4'd11, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Control sequencer that runs 4-bit shift-add multiply and restoring divide on the existing ALU/accumulator datapath. It sits directly upstream of the ALU and ACC. On a start request it drives the ALU op strobes, the ACC high/low shift-load selects, the fill bit and the ACC-high clear, cycle by cycle. The 8-bit product or the quotient/remainder is left in ACC high:low.

## Interface
Parameters: none (datapath width fixed at 4 bits).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `mode` in 1: 0 = multiply, 1 = divide; latched with `start`.
- `breg_data` in 4: divisor/multiplicand currently on the B register.
- `alu_cout` in 1: combinational ALU carry-out (no borrow when subtracting).
- `carry_flag` in 1: registered ALU carry flag.
- `acc_low_lsb` in 1: ACC low register bit 0.
- `op_mul`, `op_div` out 1 each: ALU op strobes.
- `alu_lsb` out 1: multiplier bit qualifying the carry flag.
- `acc_in_select` out 1: constant 0 while busy, so ACC high takes ALU output.
- `acc_high_select`, `acc_low_select` out 2 each: 00 hold, 01 shift right, 10 shift left, 11 load.
- `fill_value` out 1: shift-in bit to ACC.
- `acc_high_clear` out 1: active-high, drives the ACC high clear.
- `busy` out 1, `done` out 1, `div_by_zero` out 1.

## Operation
- States: IDLE, CLEAR, MUL_ADD, MUL_SHIFT, DIV_SHIFT, DIV_SUB, DIV_FIX, DONE. There is a 2-bit iteration counter `cnt`.
- Idle outputs (also every output's reset value): all strobes 0, selects 00, fill 0, clear 0, busy 0, done 0, div_by_zero 0.
- IDLE, `start`=1:
  - If `mode`=1 and `breg_data`=0: go to DONE with `div_by_zero`=1. ACC is untouched.
  - Otherwise: latch `mode`, clear `div_by_zero`, `cnt`=0, go to CLEAR.
- CLEAR: `acc_high_clear`=1, selects 00. Go to MUL_ADD if `mode`=0, else DIV_SHIFT.
- MUL_ADD:
  - `op_mul`=1, `alu_lsb`=`acc_low_lsb`.
  - If `acc_low_lsb`=1, `acc_high_select`=11 (load sum); else 00. `acc_low_select`=00.
  - Go to MUL_SHIFT.
- MUL_SHIFT:
  - Both selects 01; `fill_value`=`carry_flag` (the carry flag is 0 when no add occurred).
  - If `cnt`=3, go to DONE; else `cnt`+1 and go to MUL_ADD.
- DIV_SHIFT:
  - Both selects 10; `fill_value`=`qbit`, an internal register that is 0 on entry to the divide.
  - Go to DIV_SUB.
- DIV_SUB:
  - `op_div`=1. `qbit` <= `alu_cout`.
  - If `alu_cout`=1, `acc_high_select`=11 (keep the difference); else 00 (implicit restore). `acc_low_select`=00.
  - If `cnt`=3, go to DIV_FIX; else `cnt`+1 and go to DIV_SHIFT.
- DIV_FIX: `acc_low_select`=10, `acc_high_select`=00, `fill_value`=`qbit`. Go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0. Go to IDLE. `div_by_zero` holds until the next accepted `start`.
- Results:
  - Multiply: {ACC high, ACC low} = A×B, with A preloaded in ACC low.
  - Divide: ACC low = quotient, ACC high = remainder, with the dividend preloaded in ACC low.
- `op_add` and `op_sub` are never driven, so the zero and sign flags are unaffected.

## Timing
- `busy`=1 in CLEAR through DIV_FIX/MUL_SHIFT, i.e. every state except IDLE and DONE.
- Multiply: `start` sampled at edge 0. `done` is high in cycle 10 (1 CLEAR + 4×2 + DONE).
- Divide: `done` is high in cycle 11 (1 + 4×2 + 1 FIX + DONE).
- Divide by zero: `done` is high in cycle 1; `busy` never asserts.
- `start` while not in IDLE is ignored, and `mode` is not re-sampled. `start` held high re-triggers the cycle after DONE.
- The select/op outputs in MUL_ADD and DIV_SUB are Mealy: same-cycle functions of `acc_low_lsb` and `alu_cout`. All other outputs are functions of the state only.
- `reset_n`=0 at any edge, including mid-operation: next state IDLE, `cnt`=0, `qbit`=0, `div_by_zero`=0, all outputs at idle values from the following cycle. ACC contents after an aborted operation are undefined.

## Test plan
- Multiply 13×11 (ACC low=D, B=B): `done` at cycle 10; ACC high=8, low=F (0x8F). No select is active after DONE.
- Multiply 15×15: exercises the carry fill. Result high=E, low=1 (0xE1). `carry_flag` fill observed =1 in at least one MUL_SHIFT.
- Multiply 0×9 and 9×0: result 0x00. `acc_high_select`=00 in every MUL_ADD for the 0 multiplier.
- Divide 13/3: `done` at cycle 11; low=4, high=1. Divide 15/1: low=F, high=0. `div_by_zero`=0 in both.
- Divide 7/0: `done` at cycle 1, `div_by_zero`=1, ACC unchanged at 0x07, no strobes asserted. The next valid `start` clears the flag.
- `reset_n` pulsed low during MUL_SHIFT of iteration 2: outputs idle the next cycle. A `start` pulse during `busy` is ignored. A new 13×11 afterwards completes correctly.
